// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared constants for the machine-mode trap controller: CSR addresses, CSR
// operation encodings, mstatus bit positions, the external-interrupt cause
// value, the trap/MRET state encoding and the mstatus update helpers.
// -----------------------------------------------------------------------------
package csr_pkg;

   // Machine-mode CSR addresses touched by the trap sequencer
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // csr_op encodings; pure reads are issued with the NONE code and no write
   localparam logic [2:0] CSR_OP_NONE = 3'b000;
   localparam logic [2:0] CSR_OP_RW   = 3'b001;

   // mstatus fields
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // mcause for a machine external interrupt (interrupt bit + code 11)
   localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      T_MEPC    = 4'd1,
      T_MCAUSE  = 4'd2,
      T_MTVAL   = 4'd3,
      T_MSTATUS = 4'd4,
      T_MTVEC   = 4'd5,
      M_MSTATUS = 4'd6,
      M_MEPC    = 4'd7,
      REDIRECT  = 4'd8
   } trap_state_e;

   // mstatus on trap entry: stash MIE in MPIE, disable interrupts, MPP = M
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] old_val);
      logic [31:0] new_val;
      new_val                               = old_val;
      new_val[MSTATUS_MPIE]                 = old_val[MSTATUS_MIE];
      new_val[MSTATUS_MIE]                  = 1'b0;
      new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return new_val;
   endfunction

   // mstatus on MRET: restore MIE from MPIE, set MPIE, MPP stays M (only mode)
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] old_val);
      logic [31:0] new_val;
      new_val                               = old_val;
      new_val[MSTATUS_MIE]                  = old_val[MSTATUS_MPIE];
      new_val[MSTATUS_MPIE]                 = 1'b1;
      new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return new_val;
   endfunction

endpackage

// File: rtl/csr_port_mux.sv
// -----------------------------------------------------------------------------
// csr_port_mux
// Arbitrates the single CSR-file port between the trap sequencer and the
// pipeline. The sequencer always wins; the pipeline is granted only when the
// controller enables it. With neither active, every csr_* output is zero.
//   pipe_en        : controller allows a pipeline grant this cycle
//   pipe_csr_*     : pipeline CSR request / grant
//   fsm_*          : sequencer CSR access (fsm_act qualifies the rest)
//   csr_*          : CSR-file port
// -----------------------------------------------------------------------------
module csr_port_mux
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            pipe_en,
   input  logic            pipe_csr_req,
   input  logic [2:0]      pipe_csr_op,
   input  logic [11:0]     pipe_csr_addr,
   input  logic [XLEN-1:0] pipe_csr_wdata,
   output logic            pipe_csr_gnt,
   input  logic            fsm_act,
   input  logic            fsm_wr,
   input  logic [2:0]      fsm_op,
   input  logic [11:0]     fsm_addr,
   input  logic [XLEN-1:0] fsm_wdata,
   output logic            csr_wr_en,
   output logic [2:0]      csr_op,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata
);

   // Port selection: sequencer, then granted pipeline, else quiet zeros
   always_comb begin
      pipe_csr_gnt = pipe_en & pipe_csr_req & ~fsm_act;
      csr_wr_en    = 1'b0;
      csr_op       = CSR_OP_NONE;
      csr_addr     = 12'h000;
      csr_wdata    = '0;
      if (fsm_act) begin
         csr_wr_en = fsm_wr;
         csr_op    = fsm_op;
         csr_addr  = fsm_addr;
         csr_wdata = fsm_wdata;
      end else if (pipe_csr_gnt) begin
         csr_wr_en = 1'b1;
         csr_op    = pipe_csr_op;
         csr_addr  = pipe_csr_addr;
         csr_wdata = pipe_csr_wdata;
      end else begin
         csr_wr_en = 1'b0;
         csr_op    = CSR_OP_NONE;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap / MRET sequencer. Accepts one event in IDLE (exception >
// MRET > interrupt), walks the CSR updates one cycle per state, then pulses a
// fetch redirect. In IDLE with no event the pipeline owns the CSR port.
//   clk, rst                 : clock, synchronous active-high reset
//   exc_*                    : synchronous exception and its cause/pc/tval
//   irq_pending, irq_pc      : gated external interrupt and its resume PC
//   mret_valid               : MRET retiring
//   pipe_csr_*               : pipeline CSR request / grant
//   csr_*                    : CSR-file port (csr_rdata is combinational)
//   stall                    : pipeline hold
//   redirect_valid/_pc       : one-cycle fetch redirect
// -----------------------------------------------------------------------------
module trap_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            irq_pending,
   input  logic [XLEN-1:0] irq_pc,
   input  logic            mret_valid,
   input  logic            pipe_csr_req,
   input  logic [2:0]      pipe_csr_op,
   input  logic [11:0]     pipe_csr_addr,
   input  logic [XLEN-1:0] pipe_csr_wdata,
   output logic            pipe_csr_gnt,
   output logic            csr_wr_en,
   output logic [2:0]      csr_op,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   trap_state_e     state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic [XLEN-1:0] target_q, target_d;

   logic            is_idle;
   logic            any_event;
   logic            fsm_act;
   logic            fsm_wr;
   logic [2:0]      fsm_op;
   logic [11:0]     fsm_addr;
   logic [XLEN-1:0] fsm_wdata;

   assign is_idle   = (state_q == IDLE);
   assign any_event = exc_valid | mret_valid | irq_pending;

   // Next-state, latch updates and the sequencer's CSR access per state
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cause_d   = cause_q;
      tval_d    = tval_q;
      target_d  = target_q;
      fsm_act   = 1'b0;
      fsm_wr    = 1'b0;
      fsm_op    = CSR_OP_NONE;
      fsm_addr  = 12'h000;
      fsm_wdata = '0;
      case (state_q)
         IDLE: begin
            if (exc_valid) begin
               state_d = T_MEPC;
               pc_d    = exc_pc;
               cause_d = {{(XLEN-4){1'b0}}, exc_cause};
               tval_d  = exc_tval;
            end else if (mret_valid) begin
               state_d = M_MSTATUS;
            end else if (irq_pending) begin
               state_d = T_MEPC;
               pc_d    = irq_pc;
               cause_d = IRQ_CAUSE;
               tval_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         T_MEPC: begin
            fsm_act   = 1'b1;
            fsm_wr    = 1'b1;
            fsm_op    = CSR_OP_RW;
            fsm_addr  = CSR_MEPC;
            fsm_wdata = pc_q;
            state_d   = T_MCAUSE;
         end
         T_MCAUSE: begin
            fsm_act   = 1'b1;
            fsm_wr    = 1'b1;
            fsm_op    = CSR_OP_RW;
            fsm_addr  = CSR_MCAUSE;
            fsm_wdata = cause_q;
            state_d   = T_MTVAL;
         end
         T_MTVAL: begin
            fsm_act   = 1'b1;
            fsm_wr    = 1'b1;
            fsm_op    = CSR_OP_RW;
            fsm_addr  = CSR_MTVAL;
            fsm_wdata = tval_q;
            state_d   = T_MSTATUS;
         end
         T_MSTATUS: begin
            // read-modify-write in one cycle through the combinational read
            fsm_act   = 1'b1;
            fsm_wr    = 1'b1;
            fsm_op    = CSR_OP_RW;
            fsm_addr  = CSR_MSTATUS;
            fsm_wdata = mstatus_on_trap(csr_rdata);
            state_d   = T_MTVEC;
         end
         T_MTVEC: begin
            // direct mode only: mode bits are dropped from the target
            fsm_act  = 1'b1;
            fsm_addr = CSR_MTVEC;
            target_d = {csr_rdata[XLEN-1:2], 2'b00};
            state_d  = REDIRECT;
         end
         M_MSTATUS: begin
            fsm_act   = 1'b1;
            fsm_wr    = 1'b1;
            fsm_op    = CSR_OP_RW;
            fsm_addr  = CSR_MSTATUS;
            fsm_wdata = mstatus_on_mret(csr_rdata);
            state_d   = M_MEPC;
         end
         M_MEPC: begin
            fsm_act  = 1'b1;
            fsm_addr = CSR_MEPC;
            target_d = {csr_rdata[XLEN-1:1], 1'b0};
            state_d  = REDIRECT;
         end
         REDIRECT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latch registers; reset aborts any sequence in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         cause_q  <= '0;
         tval_q   <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cause_q  <= cause_d;
         tval_q   <= tval_d;
         target_q <= target_d;
      end
   end

   // A reset cycle issues no CSR access and no redirect, so an abort in the
   // middle of a sequence leaves only the writes already committed.
   csr_port_mux #(
      .XLEN(XLEN)
   ) u_csr_port_mux (
      .pipe_en        (is_idle & ~any_event & ~rst),
      .pipe_csr_req   (pipe_csr_req),
      .pipe_csr_op    (pipe_csr_op),
      .pipe_csr_addr  (pipe_csr_addr),
      .pipe_csr_wdata (pipe_csr_wdata),
      .pipe_csr_gnt   (pipe_csr_gnt),
      .fsm_act        (fsm_act & ~rst),
      .fsm_wr         (fsm_wr),
      .fsm_op         (fsm_op),
      .fsm_addr       (fsm_addr),
      .fsm_wdata      (fsm_wdata),
      .csr_wr_en      (csr_wr_en),
      .csr_op         (csr_op),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata)
   );

   // Hold the pipeline from the accepting cycle through REDIRECT
   assign stall          = ~is_idle | any_event;
   assign redirect_valid = (state_q == REDIRECT) & ~rst;
   assign redirect_pc    = redirect_valid ? target_q : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed plus randomized checks of trap_ctrl. The bench owns a behavioural
// CSR file (array + write log) and predicts every write and redirect from the
// architectural trap / MRET rules.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

   logic        clk;
   logic        rst;
   logic        exc_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        irq_pending;
   logic [31:0] irq_pc;
   logic        mret_valid;
   logic        pipe_csr_req;
   logic [2:0]  pipe_csr_op;
   logic [11:0] pipe_csr_addr;
   logic [31:0] pipe_csr_wdata;
   logic        pipe_csr_gnt;
   logic        csr_wr_en;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural CSR file with a log of every write strobe
   logic [31:0] csr_mem [0:4095];
   logic [11:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];

   assign csr_rdata = csr_mem[csr_addr];

   always @(posedge clk) begin
      if (csr_wr_en) begin
         if (csr_op == 3'b001) csr_mem[csr_addr] <= csr_wdata;
         wr_addr_q.push_back(csr_addr);
         wr_data_q.push_back(csr_wdata);
      end
   end

   trap_ctrl #(.XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .irq_pending    (irq_pending),
      .irq_pc         (irq_pc),
      .mret_valid     (mret_valid),
      .pipe_csr_req   (pipe_csr_req),
      .pipe_csr_op    (pipe_csr_op),
      .pipe_csr_addr  (pipe_csr_addr),
      .pipe_csr_wdata (pipe_csr_wdata),
      .pipe_csr_gnt   (pipe_csr_gnt),
      .csr_wr_en      (csr_wr_en),
      .csr_op         (csr_op),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      exc_valid      = 1'b0;
      exc_cause      = 4'h0;
      exc_pc         = 32'h0;
      exc_tval       = 32'h0;
      irq_pending    = 1'b0;
      irq_pc         = 32'h0;
      mret_valid     = 1'b0;
      pipe_csr_req   = 1'b0;
      pipe_csr_op    = 3'b000;
      pipe_csr_addr  = 12'h000;
      pipe_csr_wdata = 32'h0;
   endtask

   // Expected mstatus after trap entry / MRET, from the field rules
   function automatic logic [31:0] ref_trap_ms(input logic [31:0] o);
      return (o & ~32'h0000_1888) | 32'h0000_1800 | (((o >> 3) & 32'h1) << 7);
   endfunction

   function automatic logic [31:0] ref_mret_ms(input logic [31:0] o);
      return (o & ~32'h0000_1888) | 32'h0000_1880 | (((o >> 7) & 32'h1) << 3);
   endfunction

   // One pipeline CSR access in IDLE; optionally checks the passthrough
   task automatic pipe_access(input logic [2:0] op, input logic [11:0] addr,
                              input logic [31:0] data, input bit do_check);
      pipe_csr_req   = 1'b1;
      pipe_csr_op    = op;
      pipe_csr_addr  = addr;
      pipe_csr_wdata = data;
      #1;
      if (do_check) begin
         check("pipe_gnt",   {31'h0, pipe_csr_gnt}, 32'h1);
         check("pipe_wr_en", {31'h0, csr_wr_en},    32'h1);
         check("pipe_op",    {29'h0, csr_op},       {29'h0, op});
         check("pipe_addr",  {20'h0, csr_addr},     {20'h0, addr});
         check("pipe_wdata", csr_wdata,             data);
         check("pipe_stall", {31'h0, stall},        32'h0);
      end
      tick();
      clear_inputs();
   endtask

   // Preload CSRs, fire an event set, check timing, redirect and write log
   task automatic run_event(input string tag, input bit e, input bit m, input bit i,
                            input bit p, input logic [31:0] mst, input logic [31:0] mtv,
                            input logic [31:0] mep, input logic [31:0] pc,
                            input logic [3:0] cause, input logic [31:0] tval,
                            input logic [31:0] ipc);
      logic [11:0] ea [4];
      logic [31:0] ed [4];
      int          en;
      int          r_at;
      int          start;
      logic [31:0] tgt;
      pipe_access(3'b001, 12'h300, mst, 1'b0);
      pipe_access(3'b001, 12'h305, mtv, 1'b0);
      pipe_access(3'b001, 12'h341, mep, 1'b0);
      start = wr_addr_q.size();
      if (e || (!m && i)) begin
         en = 4; r_at = 6; tgt = mtv & 32'hFFFF_FFFC;
         ea[0] = 12'h341; ed[0] = e ? pc : ipc;
         ea[1] = 12'h342; ed[1] = e ? {28'h0, cause} : 32'h8000_000B;
         ea[2] = 12'h343; ed[2] = e ? tval : 32'h0;
         ea[3] = 12'h300; ed[3] = ref_trap_ms(mst);
      end else begin
         en = 1; r_at = 3; tgt = mep & 32'hFFFF_FFFE;
         ea[0] = 12'h300; ed[0] = ref_mret_ms(mst);
         ea[1] = 12'h0; ed[1] = 32'h0; ea[2] = 12'h0; ed[2] = 32'h0;
         ea[3] = 12'h0; ed[3] = 32'h0;
      end
      exc_valid = e; exc_cause = cause; exc_pc = pc; exc_tval = tval;
      mret_valid = m; irq_pending = i; irq_pc = ipc;
      pipe_csr_req = p; pipe_csr_op = 3'b001;
      pipe_csr_addr = 12'h340; pipe_csr_wdata = $urandom;
      #1;
      check({tag, ".acc_stall"}, {31'h0, stall},          32'h1);
      check({tag, ".acc_gnt"},   {31'h0, pipe_csr_gnt},   32'h0);
      check({tag, ".acc_wr"},    {31'h0, csr_wr_en},      32'h0);
      for (int k = 1; k <= r_at + 1; k++) begin
         tick();
         if (k <= r_at) begin
            // events and requests here fall outside IDLE and must be ignored
            exc_valid      = 1'($urandom);
            mret_valid     = 1'($urandom);
            irq_pending    = 1'($urandom);
            pipe_csr_req   = 1'($urandom);
            pipe_csr_op    = 3'b001;
            pipe_csr_addr  = 12'($urandom);
            pipe_csr_wdata = $urandom;
         end else begin
            clear_inputs();
         end
         #1;
         check({tag, ".rv"}, {31'h0, redirect_valid}, (k == r_at) ? 32'h1 : 32'h0);
         check({tag, ".rpc"}, redirect_pc, (k == r_at) ? tgt : 32'h0);
         check({tag, ".stall"}, {31'h0, stall}, (k <= r_at) ? 32'h1 : 32'h0);
         check({tag, ".gnt"}, {31'h0, pipe_csr_gnt}, 32'h0);
      end
      check({tag, ".nwr"}, 32'(wr_addr_q.size() - start), 32'(en));
      for (int j = 0; j < en; j++) begin
         if (start + j < wr_addr_q.size()) begin
            check({tag, ".wa"}, {20'h0, wr_addr_q[start + j]}, {20'h0, ea[j]});
            check({tag, ".wd"}, wr_data_q[start + j], ed[j]);
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_stall", {31'h0, stall},          32'h0);
      check("rst_rv",    {31'h0, redirect_valid}, 32'h0);
      check("rst_rpc",   redirect_pc,             32'h0);
      check("rst_gnt",   {31'h0, pipe_csr_gnt},   32'h0);
      check("rst_wr",    {31'h0, csr_wr_en},      32'h0);
      check("rst_op",    {29'h0, csr_op},         32'h0);
      check("rst_addr",  {20'h0, csr_addr},       32'h0);
      check("rst_wdata", csr_wdata,               32'h0);

      // pipeline passthrough in IDLE
      pipe_access(3'b001, 12'h340, 32'h55, 1'b1);
      check("mscratch", csr_mem[12'h340], 32'h55);
      for (int n = 0; n < 6; n++) begin
         pipe_access(3'($urandom_range(1, 7)), 12'($urandom), $urandom, 1'b1);
      end

      // directed scenarios
      run_event("exc",  1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h8001, 32'h0,
                32'h100, 4'd2, 32'hDEAD, 32'h0);
      check("exc_mstatus", csr_mem[12'h300], 32'h1880);
      run_event("irq",  1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h8001, 32'h0,
                32'h0, 4'd0, 32'h0, 32'h204);
      run_event("mret", 1'b0, 1'b1, 1'b0, 1'b0, 32'h1880, 32'h8001, 32'h103,
                32'h0, 4'd0, 32'h0, 32'h0);
      check("mret_mstatus", csr_mem[12'h300], 32'h1888);
      run_event("all4", 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h4000_0003, 32'h0,
                32'h500, 4'd7, 32'h1234, 32'h600);

      // randomized events
      for (int n = 0; n < 12; n++) begin
         int  kind;
         bit  e, m, i;
         kind = int'($urandom_range(0, 2));
         e = (kind == 0);
         m = (kind == 1) || ((kind == 0) && 1'($urandom));
         i = (kind == 2) || ((kind < 2) && 1'($urandom));
         run_event("rnd", e, m, i, 1'($urandom), $urandom, $urandom, $urandom,
                   $urandom, 4'($urandom), $urandom, $urandom);
      end

      // reset while in T_MTVAL aborts the trap
      pipe_access(3'b001, 12'h300, 32'h8, 1'b0);
      pipe_access(3'b001, 12'h305, 32'h8001, 1'b0);
      exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h700; exc_tval = 32'h77;
      tick();
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_stall", {31'h0, stall},          32'h0);
      check("abort_rv",    {31'h0, redirect_valid}, 32'h0);
      check("abort_rpc",   redirect_pc,             32'h0);
      check("abort_wr",    {31'h0, csr_wr_en},      32'h0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("abort_norv", {31'h0, redirect_valid}, 32'h0);
      end
      check("abort_mstatus", csr_mem[12'h300], 32'h8);
      check("abort_mepc",    csr_mem[12'h341], 32'h700);
      check("abort_mcause",  csr_mem[12'h342], 32'h5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
